// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // Default data-memory address width (memory depth is 2**AW bytes).
  parameter int DEF_AW = 8;

  // Width of the optional access counters.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD_RD = 2'd1,
    LD_WB = 2'd2,
    ST_WR = 2'd3
  } lsu_state_t;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ld_st_unit_if.sv
// Request / writeback bundle between the decode/execute stage and the
// load/store unit. The counter signals exist only when LSU_CNT_EN is defined.
//
// Handshake: the requester raises req_valid with req_we/req_addr/req_wdata
// stable and holds all of them until it sees req_ready; a request transfers
// on the rising edge where req_valid && req_ready. req_valid seen while the
// unit is busy (req_ready low) is ignored, never queued.
interface ld_st_unit_if #(
  parameter int AW = lsu_pkg::DEF_AW
) ();

  logic                     req_valid;
  logic                     req_we;
  logic [AW-1:0]            req_addr;
  logic [7:0]               req_wdata;
  logic                     req_ready;
  logic                     stall;
  logic [7:0]               wb_data;
  logic                     wb_mem_to_reg;
  logic                     st_done;
  lsu_pkg::lsu_state_t      dbg_state;
`ifdef LSU_CNT_EN
  logic [lsu_pkg::CNT_W-1:0] ld_count;
  logic [lsu_pkg::CNT_W-1:0] st_count;
`endif

  // Unit side.
  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output stall,
    output wb_data,
    output wb_mem_to_reg,
    output st_done,
`ifdef LSU_CNT_EN
    output ld_count,
    output st_count,
`endif
    output dbg_state
  );

  // Requester side.
  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  stall,
    input  wb_data,
    input  wb_mem_to_reg,
    input  st_done,
`ifdef LSU_CNT_EN
    input  ld_count,
    input  st_count,
`endif
    input  dbg_state
  );

endinterface

// File: rtl/ld_st_unit_dmem.sv
// Single-port byte-wide synchronous data memory. Reads are registered with
// one cycle of latency and only update the read register when re_i is high,
// so rdata_o holds the last loaded byte between loads.
module dmem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  localparam int DEPTH = 1 << AW;

  // Contents are zero at power-up only; reset does not clear the array.
  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};
  logic [7:0] rdata_q;

  // Write port: commits on the edge that leaves the store state.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read; cleared by reset so the writeback byte restarts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 8'h00;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ld_st_unit.sv
// Multi-cycle load/store unit in front of the register-file write port.
// One access in flight at a time: loads take LD_RD then LD_WB (writeback
// pulse), stores take ST_WR (memory write + st_done pulse).
// Optional feature macro: LSU_CNT_EN adds saturating load/store counters.
module ld_st_unit
  import lsu_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input logic         clk,
  input logic         reset,
  ld_st_unit_if.slave bus
);

  lsu_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          accept;
  logic          req_ready;
  logic          wb_pulse;
  logic          st_pulse;
  logic          mem_re;
  logic          mem_we;
  logic [7:0]    mem_rdata;

  // The load/store direction is carried by the state itself, so no
  // separate direction register is kept.
  assign accept = bus.req_valid && (state_q == IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    wb_pulse  = 1'b0;
    st_pulse  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = bus.req_we ? ST_WR : LD_RD;
        end
      end
      LD_RD: begin
        mem_re  = 1'b1;
        state_d = LD_WB;
      end
      LD_WB: begin
        wb_pulse = 1'b1;
        state_d  = IDLE;
      end
      ST_WR: begin
        mem_we   = 1'b1;
        st_pulse = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch next values: capture only on acceptance.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end
  end

  // Request latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= 8'h00;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  dmem #(
    .AW(AW)
  ) u_dmem (
    .clk     (clk),
    .reset   (reset),
    .re_i    (mem_re),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready     = req_ready;
  assign bus.stall         = ~req_ready;
  assign bus.wb_data       = mem_rdata;
  assign bus.wb_mem_to_reg = wb_pulse;
  assign bus.st_done       = st_pulse;
  assign bus.dbg_state     = state_q;

`ifdef LSU_CNT_EN
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  // Counter next values: bump on acceptance, saturating at all-ones.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (accept && !bus.req_we) begin
      ld_cnt_d = sat_inc(ld_cnt_q);
    end
    if (accept && bus.req_we) begin
      st_cnt_d = sat_inc(st_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign bus.ld_count = ld_cnt_q;
  assign bus.st_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_ld_st_unit.sv
// Self-checking bench for ld_st_unit: directed scenarios plus random traffic,
// with a byte-array memory model and an expected-response queue.
module tb_ld_st_unit;
  import lsu_pkg::*;

  localparam int AW = 8;
  // Queue entry: {is_load, data, expected cycle of the pulse}.
  localparam int W  = 1 + 8 + 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ld_st_unit_if #(.AW(AW)) bus ();

  ld_st_unit #(.AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   ref_mem [256];
  int unsigned  wb_cyc_q[$];
  logic [7:0]   last_ld = 8'h00;
  int           n_pass  = 0;
  int           n_total = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      last_ld = 8'h00;
    end else begin
      check("stall_vs_ready", {31'd0, bus.stall}, {31'd0, ~bus.req_ready});
      if (bus.wb_mem_to_reg || bus.st_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, bus.wb_mem_to_reg, bus.st_done}, 32'd0);
          if (bus.wb_mem_to_reg) last_ld = bus.wb_data;
        end else begin
          e = exp_q.pop_front();
          if (e[W-1]) begin
            check("ld_kind", {30'd0, bus.wb_mem_to_reg, bus.st_done}, 32'd2);
            check("ld_data", {24'd0, bus.wb_data}, {24'd0, e[39:32]});
            check("ld_latency", cyc, e[31:0]);
            last_ld = e[39:32];
            wb_cyc_q.push_back(cyc);
          end else begin
            check("st_kind", {30'd0, bus.wb_mem_to_reg, bus.st_done}, 32'd1);
            check("st_latency", cyc, e[31:0]);
            check("wb_hold_st", {24'd0, bus.wb_data}, {24'd0, last_ld});
          end
        end
      end else begin
        check("wb_hold", {24'd0, bus.wb_data}, {24'd0, last_ld});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a falling edge. Holds the request until accepted; with chk the
  // expected pulse is queued and the busy flags are checked one cycle later,
  // without chk the task returns just after the accepting edge.
  task automatic issue(input logic we, input logic [7:0] addr,
                       input logic [7:0] data, input bit chk);
    int budget = 0;
    bit got = 0;
    int unsigned acc;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (!got && budget < 20) begin
      if (bus.req_ready) got = 1;
      else begin
        @(negedge clk);
        budget++;
      end
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (chk) begin
      if (we) begin
        ref_mem[addr] = data;
        exp_q.push_back({1'b0, data, 32'(acc + 1)});
      end else begin
        exp_q.push_back({1'b1, ref_mem[addr], 32'(acc + 2)});
      end
    end
    @(posedge clk);
    if (chk) begin
      @(negedge clk);
      check("busy_flags", {30'd0, bus.stall, bus.req_ready}, 32'd2);
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int budget = 0;
    bus.req_valid = 1'b0;
    while ((exp_q.size() != 0 || !bus.req_ready) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_reset();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_wb_data", {24'd0, bus.wb_data}, 32'd0);
    check("rst_wb_pulse", {31'd0, bus.wb_mem_to_reg}, 32'd0);
    check("rst_st_done", {31'd0, bus.st_done}, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
`ifdef LSU_CNT_EN
    check("rst_ld_count", {16'd0, bus.ld_count}, 32'd0);
    check("rst_st_count", {16'd0, bus.st_count}, 32'd0);
`endif

    // Store then load at 0x10.
    issue(1'b1, 8'h10, 8'hA5, 1'b1);
    idle(2);
    issue(1'b0, 8'h10, 8'h00, 1'b1);
    drain();

    // Preload 0..2, then three loads with req_valid held high throughout.
    issue(1'b1, 8'h00, 8'h01, 1'b1);
    issue(1'b1, 8'h01, 8'h02, 1'b1);
    issue(1'b1, 8'h02, 8'h03, 1'b1);
    drain();
    wb_cyc_q.delete();
    issue(1'b0, 8'h00, 8'h00, 1'b1);
    issue(1'b0, 8'h01, 8'h00, 1'b1);
    issue(1'b0, 8'h02, 8'h00, 1'b1);
    drain();
    check("b2b_pulse_count", wb_cyc_q.size(), 32'd3);
    if (wb_cyc_q.size() == 3) begin
      check("b2b_spacing_1", wb_cyc_q[1] - wb_cyc_q[0], 32'd3);
      check("b2b_spacing_2", wb_cyc_q[2] - wb_cyc_q[1], 32'd3);
    end

    // Top address, store immediately followed by load.
    issue(1'b1, 8'hFF, 8'h3C, 1'b1);
    issue(1'b0, 8'hFF, 8'h00, 1'b1);
    drain();

    // Reset during ST_WR: the store must not land.
    issue(1'b1, 8'h20, 8'h77, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("abort_st_done", {31'd0, bus.st_done}, 32'd0);
    check("abort_st_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 8'h20, 8'h00, 1'b1);
    issue(1'b0, 8'h10, 8'h00, 1'b1);
    drain();

    // Reset during LD_RD: no writeback, wb_data cleared, ready at once.
    issue(1'b0, 8'h10, 8'h00, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("abort_ld_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_ld_wb_data", {24'd0, bus.wb_data}, 32'd0);
    check("abort_ld_pulse", {31'd0, bus.wb_mem_to_reg}, 32'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_abort_wb_data", {24'd0, bus.wb_data}, 32'd0);

    // Random traffic against the memory model.
    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic [7:0]  addr, data;
      we   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 255));
      data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue(we, addr, data, 1'b1);
    end
    drain();

`ifdef LSU_CNT_EN
    pulse_reset();
    for (int i = 0; i < 5; i++) issue(1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) issue(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    drain();
    check("ld_count_5", {16'd0, bus.ld_count}, 32'd5);
    check("st_count_2", {16'd0, bus.st_count}, 32'd2);
    force dut.ld_cnt_q = 16'hFFFE;
    #1 release dut.ld_cnt_q;
    @(negedge clk);
    for (int i = 0; i < 3; i++) issue(1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'b1);
    drain();
    check("ld_count_sat", {16'd0, bus.ld_count}, 32'h0000FFFF);
    check("st_count_hold", {16'd0, bus.st_count}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit reached");
  end

endmodule
